// File: rtl/rx_sample_buffer.sv
// rtl/rx_sample_buffer.sv - I/Q sample FIFO between the DDC and the RX packetiser
// Optional: define RX_SAMPLE_BUFFER_OVFL_CNT_EN to build the saturating dropped-sample counter;
// otherwise overflow_count is tied to 0 and only the overflow pulse remains.
module rx_sample_buffer #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        iq_valid,
  input  logic [23:0] i_data,
  input  logic [23:0] q_data,
  input  logic        rx_request,
  output logic [47:0] rx_data,
  output logic [10:0] rx_length,
  output logic        overflow,
  output logic [15:0] overflow_count
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [10:0]           FULL_LEN = 11'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [47:0]           r_mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [10:0]           r_length;
  logic [47:0]           r_data;
  logic                  r_overflow;
  logic                  r_live;

  logic w_full;
  logic w_rd;
  logic w_wr;
  logic w_drop;

  // A read frees its slot on the same edge, so a full buffer with a read still accepts a sample.
  assign w_full = (r_length == FULL_LEN);
  assign w_rd   = r_live & run & rx_request & (r_length != 11'd0);
  assign w_wr   = r_live & run & iq_valid & (~w_full | w_rd);
  assign w_drop = r_live & run & iq_valid & w_full & ~w_rd;

  // Low on the first edge after reset release so that edge neither writes nor reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_live <= 1'b0;
    else          r_live <= 1'b1;
  end

  // Sample storage; deliberately not reset, contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {i_data, q_data};
  end

  // Pointers and occupancy; run low flushes the buffer every edge it is held low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_length <= 11'd0;
    end else if (!run) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_length <= 11'd0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_wr, w_rd})
        2'b10:   r_length <= r_length + 11'd1;
        2'b01:   r_length <= r_length - 11'd1;
        default: r_length <= r_length;
      endcase
    end
  end

  // Read word register; holds the last popped word until the next read (or reset).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_data <= 48'd0;
    else if (w_rd) r_data <= r_mem[r_rd_ptr];
  end

  // One-cycle pulse per sample discarded while full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_overflow <= 1'b0;
    else          r_overflow <= w_drop;
  end

`ifdef RX_SAMPLE_BUFFER_OVFL_CNT_EN
  logic [15:0] r_ovfl_cnt;

  // Saturating dropped-sample counter, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              r_ovfl_cnt <= 16'd0;
    else if (w_drop && r_ovfl_cnt != 16'hFFFF) r_ovfl_cnt <= r_ovfl_cnt + 16'd1;
  end

  assign overflow_count = r_ovfl_cnt;
`else
  assign overflow_count = 16'd0;
`endif

  assign rx_data   = r_data;
  assign rx_length = r_length;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_rx_sample_buffer.sv
// tb/tb_rx_sample_buffer.sv - scoreboard bench for rx_sample_buffer with a queue-based reference model
module tb_rx_sample_buffer;

  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;
`ifdef RX_SAMPLE_BUFFER_OVFL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        run = 1'b0;
  logic        iq_valid = 1'b0;
  logic [23:0] i_data = 24'd0;
  logic [23:0] q_data = 24'd0;
  logic        rx_request = 1'b0;
  logic [47:0] rx_data;
  logic [10:0] rx_length;
  logic        overflow;
  logic [15:0] overflow_count;

  always #5 clk = ~clk;

  rx_sample_buffer #(.DEPTH_LOG2(DL2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .run            (run),
    .iq_valid       (iq_valid),
    .i_data         (i_data),
    .q_data         (q_data),
    .rx_request     (rx_request),
    .rx_data        (rx_data),
    .rx_length      (rx_length),
    .overflow       (overflow),
    .overflow_count (overflow_count)
  );

  typedef struct packed {
    logic [10:0] len;
    logic [47:0] data;
    logic        ovf;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [47:0] mq[$];
  logic [47:0] m_data = 48'd0;
  logic [15:0] m_cnt = 16'd0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs and push the reference model's post-edge expectation.
  task automatic step(input logic r, input logic v, input logic [23:0] i, input logic [23:0] q,
                      input logic req);
    bit   rd;
    bit   full;
    bit   ovf;
    exp_t e;
    @(negedge clk);
    run = r; iq_valid = v; i_data = i; q_data = q; rx_request = req;
    ovf = 1'b0;
    if (!r) begin
      mq.delete();
    end else begin
      rd   = req && (mq.size() > 0);
      full = (mq.size() == DEPTH);
      if (rd) m_data = mq.pop_front();
      if (v) begin
        if (!full || rd) mq.push_back({i, q});
        else begin
          ovf = 1'b1;
          if (m_cnt != 16'hFFFF) m_cnt++;
        end
      end
    end
    e.len  = 11'(mq.size());
    e.data = m_data;
    e.ovf  = ovf;
    e.cnt  = CNT_EN ? m_cnt : 16'd0;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [23:0] i, input logic [23:0] q);
    step(1'b1, 1'b1, i, q, 1'b0);
  endtask

  task automatic wr_rand();
    step(1'b1, 1'b1, 24'($urandom), 24'($urandom), 1'b0);
  endtask

  task automatic rd();
    step(1'b1, 1'b0, 24'd0, 24'd0, 1'b1);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 24'd0, 24'd0, 1'b0);
  endtask

  // Assert reset immediately (between edges), check the async clear, then release with
  // write/read stimulus held so the release edge must be ignored.
  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    run = 1'b1; iq_valid = 1'b1; i_data = 24'h5a5a5a; q_data = 24'ha5a5a5; rx_request = 1'b1;
    #1;
    chk({tag, "_rx_length"}, 64'(rx_length), 64'd0);
    chk({tag, "_rx_data"}, 64'(rx_data), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
    chk({tag, "_overflow_count"}, 64'(overflow_count), 64'd0);
    mq.delete();
    m_data = 48'd0;
    m_cnt  = 16'd0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_release_len"}, 64'(rx_length), 64'd0);
    chk({tag, "_release_ovf"}, 64'(overflow), 64'd0);
  endtask

  // Monitor: one expectation per driven cycle, compared just after the sampling edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rx_length", 64'(rx_length), 64'(e.len));
        chk("rx_data", 64'(rx_data), 64'(e.data));
        chk("overflow", 64'(overflow), 64'(e.ovf));
        chk("overflow_count", 64'(overflow_count), 64'(e.cnt));
      end
    end
  end

  initial begin
    #2;
    apply_reset("reset");

    // Basic fill and read with the reference words.
    wr(24'hafaead, 24'hacabaa);
    wr(24'h161514, 24'h131211);
    wr(24'h000001, 24'hFFFFFF);
    idle();
    rd(); rd(); rd();
    idle();

    // Empty read leaves everything unchanged.
    rd(); rd();
    idle();

    // Overflow: 18 writes into 16 slots, then drain in order.
    repeat (18) wr_rand();
    idle();
    repeat (16) rd();
    idle();

    // Simultaneous write+read at full and at length 5.
    repeat (16) wr_rand();
    step(1'b1, 1'b1, 24'($urandom), 24'($urandom), 1'b1);
    repeat (11) rd();
    step(1'b1, 1'b1, 24'($urandom), 24'($urandom), 1'b1);
    repeat (6) rd();
    idle();

    // Interleaved pairs walk both pointers around the ring several times.
    repeat (40) begin
      wr_rand();
      rd();
    end
    idle();

    // Run drop flushes; the first sample after run returns is read back first.
    repeat (12) wr_rand();
    step(1'b0, 1'b1, 24'($urandom), 24'($urandom), 1'b1);
    idle();
    step(1'b0, 1'b0, 24'd0, 24'd0, 1'b0);
    wr(24'h7e57ab, 24'h0c0ffe);
    wr_rand();
    rd(); rd();
    idle();

    // Randomised traffic biased toward filling, with occasional run drops.
    for (int n = 0; n < 300; n++) begin
      step(1'($urandom_range(0, 24) != 0), 1'($urandom_range(0, 3) != 0),
           24'($urandom), 24'($urandom), 1'($urandom_range(0, 2) == 0));
    end
    repeat (DEPTH + 2) rd();
    idle();

    // Async reset mid-stream with 7 words buffered and a freshly read word on rx_data.
    repeat (8) wr_rand();
    rd();
    idle();
    @(posedge clk);
    #2;
    apply_reset("async");
    wr_rand();
    rd();
    idle();

    repeat (4) @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
